// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: 2-flop synchronizer plus a per-channel 4-state accept FSM.
// Define SWITCH_DEBOUNCER_EDGE_PULSE_EN to build the o_rise/o_fall pulse logic; otherwise they are tied low.
//
// state      | meaning
// STABLE0    | accepted level 0, sample matches
// PEND1      | sample is 1, counting stable samples before accepting 1
// STABLE1    | accepted level 1, sample matches
// PEND0      | sample is 0, counting stable samples before accepting 0
module switch_debouncer #(
  parameter int N_CH    = 3,
  parameter int CNT_MAX = 500000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_switch,
  output logic [N_CH-1:0] o_switch,
  output logic [N_CH-1:0] o_busy,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    ST_STABLE0 = 2'd0,
    ST_PEND1   = 2'd1,
    ST_STABLE1 = 2'd2,
    ST_PEND0   = 2'd3
  } state_t;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_switch;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;
    logic          r_sw;
    logic          w_s;

    assign w_s = r_sync2[g];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_state <= ST_STABLE0;
        r_cnt   <= '0;
        r_sw    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        if (w_accept) r_sw <= ~r_sw;
      end
    end

    // Any sample disagreeing with the pending level drops straight back to the stable state.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
        ST_STABLE0: begin
          if (w_s) begin
            w_state_nxt = ST_PEND1;
            w_cnt_nxt   = '0;
          end
        end
        ST_PEND1: begin
          if (!w_s) begin
            w_state_nxt = ST_STABLE0;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_STABLE1;
            w_cnt_nxt   = '0;
            w_accept    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_STABLE1: begin
          if (!w_s) begin
            w_state_nxt = ST_PEND0;
            w_cnt_nxt   = '0;
          end
        end
        ST_PEND0: begin
          if (w_s) begin
            w_state_nxt = ST_STABLE1;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_STABLE0;
            w_cnt_nxt   = '0;
            w_accept    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_STABLE0;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign o_switch[g] = r_sw;
    assign o_busy[g]   = (r_state == ST_PEND1) || (r_state == ST_PEND0);

`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= w_accept && (r_state == ST_PEND1);
        r_fall <= w_accept && (r_state == ST_PEND0);
      end
    end

    assign o_rise[g] = r_rise;
    assign o_fall[g] = r_fall;
`else
    assign o_rise[g] = 1'b0;
    assign o_fall[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (N_CH=3, CNT_MAX=4) against a run-length reference model.
// Works with SWITCH_DEBOUNCER_EDGE_PULSE_EN defined or undefined.
module tb_switch_debouncer;
  localparam int N_CH    = 3;
  localparam int CNT_MAX = 4;
`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic            i_clk;
  logic            i_rst_n;
  logic [N_CH-1:0] i_switch;
  logic [N_CH-1:0] o_switch;
  logic [N_CH-1:0] o_busy;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;

  int n_tests = 0;
  int n_fail  = 0;

  switch_debouncer #(.N_CH(N_CH), .CNT_MAX(CNT_MAX)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_switch(i_switch),
    .o_switch(o_switch),
    .o_busy  (o_busy),
    .o_rise  (o_rise),
    .o_fall  (o_fall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: the sampled level lags the raw input by two edges; a level is accepted once
  // CNT_MAX+1 consecutive samples disagree with the current output. Busy = a run is in progress.
  logic [N_CH-1:0] m_s1, m_s2, m_out, m_busy, m_rise, m_fall;
  int              m_run [N_CH];

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      for (int c = 0; c < N_CH; c++) m_run[c] = 0;
    end else begin
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (m_s2[c] != m_out[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == CNT_MAX + 1) begin
            m_out[c] = ~m_out[c];
            if (PULSE_EN) begin
              if (m_out[c]) m_rise[c] = 1'b1;
              else          m_fall[c] = 1'b1;
            end
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = i_switch;
    end
    for (int c = 0; c < N_CH; c++) m_busy[c] = (m_run[c] != 0);
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n  = 1'b0;
    i_switch = '0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n  = 1'b0;
    i_switch = 3'b111;
    tick();
    tick();
    n_tests++;
    if ({o_switch, o_busy, o_rise, o_fall} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset: sw=%b busy=%b rise=%b fall=%b, want all 0", o_switch, o_busy, o_rise, o_fall);
    end
    i_switch = '0;
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_clean_rise();
    int nrise = 0;
    do_reset();
    i_switch = 3'b001;
    for (int e = 1; e <= 10; e++) begin
      tick();
      nrise += int'(o_rise[0]);
      n_tests++;
      if ({o_switch, o_busy, o_rise, o_fall} !== {m_out, m_busy, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL clean_rise model e%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                 o_switch, o_busy, o_rise, o_fall, m_out, m_busy, m_rise, m_fall);
      end
      n_tests++;
      if (o_switch[0] !== (e >= 7) || o_busy[0] !== (e >= 3 && e <= 6)) begin
        n_fail++;
        $display("FAIL clean_rise timing e%0d: sw0=%b busy0=%b want sw0=%0d busy0=%0d", e,
                 o_switch[0], o_busy[0], (e >= 7), (e >= 3 && e <= 6));
      end
    end
    n_tests++;
    if (nrise !== (PULSE_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL clean_rise pulses: got %0d want %0d", nrise, (PULSE_EN ? 1 : 0));
    end
  endtask

  task automatic test_short_pulse();
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      i_switch = (e <= 3) ? 3'b010 : 3'b000;
      tick();
      n_tests++;
      if ({o_switch, o_busy, o_rise, o_fall} !== {m_out, m_busy, m_rise, m_fall} ||
          o_switch[1] !== 1'b0 || o_rise !== '0) begin
        n_fail++;
        $display("FAIL short_pulse e%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                 o_switch, o_busy, o_rise, o_fall, m_out, m_busy, m_rise, m_fall);
      end
    end
    n_tests++;
    if (o_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL short_pulse busy_end: got %b want 0", o_busy[1]);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b10101;
    int nrise = 0;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      i_switch = (e <= 5) ? {2'b00, pat[5-e]} : 3'b001;
      tick();
      nrise += int'(o_rise[0]);
      n_tests++;
      if ({o_switch, o_busy, o_rise, o_fall} !== {m_out, m_busy, m_rise, m_fall} ||
          o_switch[0] !== (e >= 11)) begin
        n_fail++;
        $display("FAIL bounce e%0d: got %b/%b/%b/%b want %b/%b/%b/%b sw0=%0d", e,
                 o_switch, o_busy, o_rise, o_fall, m_out, m_busy, m_rise, m_fall, (e >= 11));
      end
    end
    n_tests++;
    if (nrise !== (PULSE_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL bounce pulses: got %0d want %0d", nrise, (PULSE_EN ? 1 : 0));
    end
  endtask

  task automatic test_reset_mid_pend();
    int nrise = 0;
    do_reset();
    i_switch = 3'b100;
    for (int e = 1; e <= 14; e++) begin
      i_rst_n = (e == 6) ? 1'b0 : 1'b1;
      tick();
      nrise += int'(o_rise[2]);
      n_tests++;
      if ({o_switch, o_busy, o_rise, o_fall} !== {m_out, m_busy, m_rise, m_fall} ||
          o_switch[2] !== (e >= 13) || (e == 5 && o_busy[2] !== 1'b1) ||
          (e == 6 && o_busy[2] !== 1'b0)) begin
        n_fail++;
        $display("FAIL reset_mid_pend e%0d: got %b/%b/%b/%b want %b/%b/%b/%b sw2=%0d", e,
                 o_switch, o_busy, o_rise, o_fall, m_out, m_busy, m_rise, m_fall, (e >= 13));
      end
    end
    i_rst_n = 1'b1;
    n_tests++;
    if (nrise !== (PULSE_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL reset_mid_pend pulses: got %0d want %0d", nrise, (PULSE_EN ? 1 : 0));
    end
  endtask

  task automatic test_simultaneous();
    int nrise [N_CH];
    int nfall [N_CH];
    for (int c = 0; c < N_CH; c++) begin nrise[c] = 0; nfall[c] = 0; end
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      i_switch = (e <= 20) ? 3'b111 : 3'b000;
      tick();
      for (int c = 0; c < N_CH; c++) begin
        nrise[c] += int'(o_rise[c]);
        nfall[c] += int'(o_fall[c]);
      end
      n_tests++;
      if ({o_switch, o_busy, o_rise, o_fall} !== {m_out, m_busy, m_rise, m_fall} ||
          (o_switch != 3'b000 && o_switch != 3'b111)) begin
        n_fail++;
        $display("FAIL simultaneous e%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                 o_switch, o_busy, o_rise, o_fall, m_out, m_busy, m_rise, m_fall);
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      n_tests++;
      if (nrise[c] !== (PULSE_EN ? 1 : 0) || nfall[c] !== (PULSE_EN ? 1 : 0)) begin
        n_fail++;
        $display("FAIL simultaneous pulses ch%0d: rise=%0d fall=%0d want %0d each", c,
                 nrise[c], nfall[c], (PULSE_EN ? 1 : 0));
      end
    end
  endtask

  task automatic test_random();
    int hold [N_CH];
    do_reset();
    for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 7);
    for (int e = 1; e <= 600; e++) begin
      for (int c = 0; c < N_CH; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          i_switch[c] = ~i_switch[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 7);
        end
      end
      i_rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
      n_tests++;
      if ({o_switch, o_busy, o_rise, o_fall} !== {m_out, m_busy, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL random e%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                 o_switch, o_busy, o_rise, o_fall, m_out, m_busy, m_rise, m_fall);
      end
    end
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_switch = '0;
    @(negedge i_clk);
    test_reset();
    test_clean_rise();
    test_short_pulse();
    test_bounce();
    test_reset_mid_pend();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
